alu_status_register: RTL

- Registered status stage directly downstream of overflow_detection in the 8-bit ALU datapath.
- On each valid ALU operation, captures the result flags N, Z, C and V.
- Keeps a sticky overflow flag and a saturating count of overflow events.
- Raises an acknowledged overflow interrupt toward the controller.

---
 rtl/alu_pkg.sv | 13 +
 rtl/sat_counter.sv | 27 ++
 rtl/alu_status_register.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath: default bus width and the
// overflow-interrupt FSM state encoding.
package alu_pkg;

  localparam int ALU_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PEND  = 2'b01,
    ST_ACKED = 2'b10
  } ovf_state_e;

endpackage : alu_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment yields 1 so the increment is not lost.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_ONE : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule : sat_counter

// File: rtl/alu_status_register.sv
// Registered N/Z/C/V status stage behind overflow_detection, with sticky
// overflow, saturating overflow count and an acknowledged overflow interrupt.
module alu_status_register
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::ALU_DATA_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [DATA_W-1:0] result,
  input  logic              carry_out,
  input  logic              overflow,
  input  logic              flag_clear,
  input  logic              cnt_clear,
  input  logic              irq_ack,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              status_valid,
  output logic              sticky_v,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              ovf_irq
);

  ovf_state_e state, next_state;
  logic       ovf_event;

  // overflow is only meaningful alongside a valid op
  assign ovf_event = op_valid & overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_n       <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      flag_v       <= 1'b0;
      status_valid <= 1'b0;
    end else begin
      status_valid <= op_valid;
      if (op_valid) begin
        flag_n <= result[DATA_W-1];
        flag_z <= (result == '0);
        flag_c <= carry_out;
        flag_v <= overflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // flag_clear has priority over irq_ack; a same-cycle event re-arms PEND
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (ovf_event) next_state = ST_PEND;
      end
      ST_PEND: begin
        if (flag_clear)   next_state = ovf_event ? ST_PEND : ST_IDLE;
        else if (irq_ack) next_state = ST_ACKED;
      end
      ST_ACKED: begin
        if (flag_clear) next_state = ovf_event ? ST_PEND : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign sticky_v = (state != ST_IDLE);
  assign ovf_irq  = (state == ST_PEND);

  sat_counter #(
    .W (CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clear),
    .inc   (ovf_event),
    .count (ovf_count)
  );

endmodule : alu_status_register
